// File: rtl/booth_dotp_pkg.sv
// booth_dotp_pkg: shared FSM encoding and parameter sanity helper for the Booth dot-product sequencer
package booth_dotp_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, OUT} state_t;

    function automatic bit acc_len_ok(int bit_len, int acc_len);
        return acc_len >= 2 * bit_len;
    endfunction

endpackage

// File: rtl/booth_dot_product_seq_if.sv
// booth_dot_product_seq_if: operand-pair input stream and dot-product result stream
interface booth_dot_product_seq_if #(
    parameter int BIT_LEN = 4,
    parameter int ACC_LEN = 12,
    parameter int CNT_LEN = 4
);
    logic               s_valid;
    logic               s_ready;
    logic [BIT_LEN-1:0] s_a;
    logic [BIT_LEN-1:0] s_b;
    logic               s_last;
    logic               m_valid;
    logic               m_ready;
    logic [ACC_LEN-1:0] m_acc;
    logic [CNT_LEN-1:0] m_count;
    logic               m_ovf;

    modport slave (
        input  s_valid, s_a, s_b, s_last, m_ready,
        output s_ready, m_valid, m_acc, m_count, m_ovf
    );

    modport master (
        output s_valid, s_a, s_b, s_last, m_ready,
        input  s_ready, m_valid, m_acc, m_count, m_ovf
    );
endinterface

// File: rtl/booth_dotp_acc.sv
// booth_dotp_acc: sign-extending product accumulator; DOTP_SAT_EN selects saturating add with sticky overflow
module booth_dotp_acc #(
    parameter int BIT_LEN = 4,
    parameter int ACC_LEN = 12
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [2*BIT_LEN-1:0] prod_i,
    output logic [ACC_LEN-1:0]   acc_o,
    output logic                 ovf_o
);
    logic [ACC_LEN-1:0] ext;
    logic [ACC_LEN-1:0] acc_q;
    logic [ACC_LEN-1:0] acc_d;

    assign ext   = ACC_LEN'($signed(prod_i));
    assign acc_o = acc_q;

`ifdef DOTP_SAT_EN
    logic [ACC_LEN:0] sum;
    logic             of;
    logic             ovf_q;

    // one guard bit: the two top sum bits disagree exactly when the signed result left the range
    assign sum   = {acc_q[ACC_LEN-1], acc_q} + {ext[ACC_LEN-1], ext};
    assign of    = sum[ACC_LEN] ^ sum[ACC_LEN-1];
    assign acc_d = of ? {sum[ACC_LEN], {(ACC_LEN-1){~sum[ACC_LEN]}}} : sum[ACC_LEN-1:0];
    assign ovf_o = ovf_q;

    // sticky overflow flag, cleared together with the accumulator
    always_ff @(posedge clk or negedge rstn)
        if (!rstn)
            ovf_q <= 1'b0;
        else
            ovf_q <= clr_i ? 1'b0 : (en_i ? (ovf_q | of) : ovf_q);
`else
    assign acc_d = acc_q + ext;
    assign ovf_o = 1'b0;
`endif

    // running sum: cleared at result handshake, updated on each captured product
    always_ff @(posedge clk or negedge rstn)
        if (!rstn)
            acc_q <= '0;
        else
            acc_q <= clr_i ? '0 : (en_i ? acc_d : acc_q);
endmodule

// File: rtl/booth_dot_product_seq.sv
// booth_dot_product_seq: feeds operand pairs to an external sequential Booth multiplier and accumulates a dot product; DOTP_SAT_EN enables saturation
module booth_dot_product_seq
    import booth_dotp_pkg::*;
#(
    parameter int BIT_LEN = 4,
    parameter int ACC_LEN = 12,
    parameter int CNT_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    booth_dot_product_seq_if.slave bus,
    output logic [BIT_LEN-1:0]    mul_in1,
    output logic [BIT_LEN-1:0]    mul_in2,
    output logic                  mul_start,
    input  logic [2*BIT_LEN-1:0]  mul_out,
    input  logic                  mul_out_r
);
    localparam bit ACC_OK = acc_len_ok(BIT_LEN, ACC_LEN);

    generate
        if (!ACC_OK) begin : g_acc_len_too_small
            $error("ACC_LEN must be at least 2*BIT_LEN");
        end
    endgenerate

    state_t             state_q;
    logic [BIT_LEN-1:0] a_q;
    logic [BIT_LEN-1:0] b_q;
    logic               last_q;
    logic               start_q;
    logic [CNT_LEN-1:0] cnt_q;
    logic               m_valid_q;
    logic               acc_en;
    logic               acc_clr;

    assign mul_in1     = a_q;
    assign mul_in2     = b_q;
    assign mul_start   = start_q;
    assign bus.s_ready = state_q == IDLE;
    assign bus.m_valid = m_valid_q;
    assign bus.m_count = cnt_q;
    assign acc_en      = state_q == WAIT_HI && mul_out_r;
    assign acc_clr     = state_q == OUT && bus.m_ready;

    // sequencer: accept pair, pulse start, wait for ready low then high, hold result until taken
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            last_q    <= 1'b0;
            start_q   <= 1'b0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE:
                    if (bus.s_valid) begin
                        a_q     <= bus.s_a;
                        b_q     <= bus.s_b;
                        last_q  <= bus.s_last;
                        start_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                ISSUE:
                    state_q <= WAIT_LO;
                WAIT_LO:
                    if (!mul_out_r)
                        state_q <= WAIT_HI;
                WAIT_HI:
                    if (mul_out_r) begin
                        cnt_q     <= &cnt_q ? cnt_q : cnt_q + CNT_LEN'(1);
                        m_valid_q <= last_q;
                        state_q   <= last_q ? OUT : IDLE;
                    end
                OUT:
                    if (bus.m_ready) begin
                        cnt_q     <= '0;
                        m_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                default:
                    state_q <= IDLE;
            endcase
        end

    booth_dotp_acc #(.BIT_LEN(BIT_LEN), .ACC_LEN(ACC_LEN)) u_acc (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (acc_clr),
        .en_i   (acc_en),
        .prod_i (mul_out),
        .acc_o  (bus.m_acc),
        .ovf_o  (bus.m_ovf)
    );
endmodule
